// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared FSM encoding, error codes and helpers for the UART frame parser.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_DATA,
        ST_CHK
    } state_t;

    localparam logic [1:0] ERR_CHK    = 2'b01;
    localparam logic [1:0] ERR_LEN    = 2'b10;
    localparam logic [1:0] ERR_TMO    = 2'b11;
    localparam logic [7:0] DEF_HEADER = 8'hA5;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/frame_timeout_timer.sv
// frame_timeout_timer: clearable inter-byte gap counter with a registered one-cycle expire pulse.
module frame_timeout_timer #(
    parameter int TIMEOUT_CYC = 50_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    output logic expire
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CW-1:0] cnt;

    // expire is registered one cycle early so the FSM acts on the cycle the count reaches TIMEOUT_CYC
    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else begin
            cnt    <= clr ? '0 : cnt + CW'(1);
            expire <= !clr && (cnt == CW'(TIMEOUT_CYC - 2));
        end

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: validates HEADER/CMD/LEN/payload/CHK byte frames from the UART receiver
// and reports decoded frames or dropped-frame errors.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] HEADER      = DEF_HEADER,
    parameter int         MAX_LEN     = 4,
    parameter int         TIMEOUT_CYC = 50_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic        frame_vld,
    output logic [7:0]  frame_cmd,
    output logic [2:0]  frame_len,
    output logic [31:0] frame_payload,
    output logic        err_vld,
    output logic [1:0]  err_code,
    output logic [7:0]  err_cnt,
    output logic        busy
);
    state_t      state;
    logic [7:0]  cmd;
    logic [7:0]  sum;
    logic [2:0]  len;
    logic [2:0]  left;
    logic [31:0] payload;
    logic        tmo_clr;
    logic        tmo_expire;

    assign tmo_clr = rx_vld || (state == ST_IDLE);
    assign busy    = (state != ST_IDLE);

    frame_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (tmo_clr),
        .expire    (tmo_expire)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            state         <= ST_IDLE;
            cmd           <= '0;
            sum           <= '0;
            len           <= '0;
            left          <= '0;
            payload       <= '0;
            frame_vld     <= 1'b0;
            frame_cmd     <= '0;
            frame_len     <= '0;
            frame_payload <= '0;
            err_vld       <= 1'b0;
            err_code      <= '0;
            err_cnt       <= '0;
        end else begin
            frame_vld <= 1'b0;
            err_vld   <= 1'b0;
            if (rx_vld) begin
                case (state)
                    ST_IDLE: if (rx_data == HEADER) state <= ST_CMD;
                    ST_CMD: begin
                        cmd   <= rx_data;
                        sum   <= rx_data;
                        state <= ST_LEN;
                    end
                    ST_LEN: begin
                        sum     <= sum + rx_data;
                        len     <= rx_data[2:0];
                        left    <= rx_data[2:0];
                        payload <= '0;
                        if (rx_data > 8'(MAX_LEN)) begin
                            err_vld  <= 1'b1;
                            err_code <= ERR_LEN;
                            err_cnt  <= sat_inc(err_cnt);
                            state    <= ST_IDLE;
                        end else begin
                            state <= (rx_data == 8'd0) ? ST_CHK : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        payload <= {payload[23:0], rx_data};
                        sum     <= sum + rx_data;
                        left    <= left - 3'd1;
                        if (left == 3'd1) state <= ST_CHK;
                    end
                    ST_CHK: begin
                        if (rx_data == sum) begin
                            frame_vld     <= 1'b1;
                            frame_cmd     <= cmd;
                            frame_len     <= len;
                            frame_payload <= payload;
                        end else begin
                            err_vld  <= 1'b1;
                            err_code <= ERR_CHK;
                            err_cnt  <= sat_inc(err_cnt);
                        end
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (tmo_expire && state != ST_IDLE) begin
                err_vld  <= 1'b1;
                err_code <= ERR_TMO;
                err_cnt  <= sat_inc(err_cnt);
                state    <= ST_IDLE;
            end
        end

endmodule
